// File: rtl/led_matrix_scan.sv
// Scans an 8x8 framebuffer into daisy-chained column/row shift registers, one row per prescaler tick.
// Optional double buffering (front/back swap on step wrap) is enabled by defining LED_SCAN_DBUF_EN.
module led_matrix_scan #(
  parameter int PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  output logic       COL_Red,
  output logic       ROW,
  output logic       mat_CLOCK,
  output logic       mat_RCLOCK,
  output logic [2:0] step,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg;
  logic [7:0]  col_sr_reg, row_sr_reg;
  logic [2:0]  bit_reg, step_reg;
  logic        phase_reg;
  logic [7:0]  scan_row;

  assign overflow = (count_reg == 16'(PRESCALE - 1));
  assign step     = step_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_reg <= '0;
    else if (overflow) count_reg <= '0;
    else               count_reg <= count_reg + 16'd1;
  end

`ifdef LED_SCAN_DBUF_EN
  logic [7:0] fb_reg [0:1][0:7];
  logic       front_reg;

  // Writes land in the back buffer; the swap happens as the last row of a frame latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          fb_reg[b][r] <= '0;
      front_reg <= 1'b0;
    end else begin
      if (wr_en) fb_reg[~front_reg][wr_row] <= wr_data;
      if (state_reg == LATCH && step_reg == 3'd7) front_reg <= ~front_reg;
    end
  end

  assign scan_row = fb_reg[front_reg][step_reg];
`else
  logic [7:0] fb_reg [0:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++)
        fb_reg[r] <= '0;
    end else if (wr_en) begin
      fb_reg[wr_row] <= wr_data;
    end
  end

  assign scan_row = fb_reg[step_reg];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Row data is snapshotted at LOAD, so later framebuffer writes only affect the next scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sr_reg <= '0;
      row_sr_reg <= '0;
      bit_reg    <= '0;
      phase_reg  <= 1'b0;
      step_reg   <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          col_sr_reg <= ~scan_row;
          row_sr_reg <= 8'h80 >> step_reg;
          bit_reg    <= '0;
          phase_reg  <= 1'b0;
        end
        SHIFT: begin
          if (phase_reg) begin
            col_sr_reg <= {col_sr_reg[6:0], 1'b1};
            row_sr_reg <= {row_sr_reg[6:0], 1'b0};
            bit_reg    <= bit_reg + 3'd1;
            phase_reg  <= 1'b0;
          end else begin
            phase_reg  <= 1'b1;
          end
        end
        LATCH:   step_reg <= step_reg + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    COL_Red    = 1'b1;
    ROW        = 1'b0;
    mat_CLOCK  = 1'b0;
    mat_RCLOCK = 1'b0;
    case (state_reg)
      IDLE:  if (overflow) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: begin
        COL_Red   = col_sr_reg[7];
        ROW       = row_sr_reg[7];
        mat_CLOCK = phase_reg;
        if (phase_reg && bit_reg == 3'd7) state_next = LATCH;
      end
      LATCH: begin
        mat_RCLOCK = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
